dfg_token_source: RTL and testbench
===================================

Name: dfg_token_source

Overview:
- Producer node for the dataflow operator fabric.
- Host-side logic preloads a stream of operand tokens into an internal FIFO. On START, the block emits the tokens on the R/D token interface, one per enabled cycle. The operator nodes consume this interface through their R_IN/D_IN inputs.
- Signals completion with a single-cycle DONE pulse.

Parameters:
- N, 16, token data width.
- DEPTH, 16, FIFO capacity in tokens; must be a power of 2.
- AW, 4, FIFO address width; must equal log2(DEPTH).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-low (0 = reset).
- EN  input  1  global fabric enable; when 0, emission and the state machine hold.
- CLEAR  input  1  synchronous flush: FIFO emptied, state forced to IDLE.
- WR_EN  input  1  host write strobe into the FIFO.
- WR_DATA  input  N  token value to load.
- START  input  1  single-cycle request to begin emission.
- FULL  output  1  FIFO holds DEPTH tokens.
- LEVEL  output  AW+1  number of tokens currently in the FIFO.
- OVF  output  1  sticky flag: a write was attempted while the FIFO was full.
- BUSY  output  1  state is RUN.
- DONE  output  1  one-cycle pulse when emission completes.
- R_OUT  output  1  token valid to downstream R_IN.
- D_OUT  output  N  token data to downstream D_IN.

Behaviour:
- Reset (RST=0, async)
  - All outputs 0: R_OUT, D_OUT, DONE, BUSY, OVF, FULL, LEVEL.
  - FIFO pointers 0; state IDLE.
  - Reset asserted mid-RUN discards remaining tokens immediately.
- FIFO
  - Write occurs when WR_EN=1 and FULL=0. Writes are accepted in any state and are independent of EN.
  - WR_EN=1 while FULL=1: data is dropped and OVF is set. OVF stays set until RST or CLEAR.
  - Pointers wrap modulo DEPTH.
  - Write and pop in the same cycle leave LEVEL unchanged. This is legal even when full, provided a pop occurs that cycle; the write is then accepted.
  - FULL = (LEVEL == DEPTH), registered, consistent with LEVEL.
- State IDLE
  - R_OUT=0; D_OUT holds its last value.
  - START=1 with LEVEL>0 -> RUN. START is honoured regardless of EN.
  - START=1 with LEVEL=0 -> DONE (empty stream).
- State RUN (BUSY=1)
  - Each cycle with EN=1 and LEVEL>0: pop the FIFO head; D_OUT <= head; R_OUT <= 1.
  - Each cycle with EN=1 and LEVEL=0: R_OUT <= 0; -> DONE.
  - EN=0: no pop, no state change; R_OUT and D_OUT hold. Downstream operators are gated by the same EN, so no token is lost or duplicated.
  - START while in RUN is ignored.
  - Host writes during RUN extend the stream. A token written before the FIFO drains is emitted in order.
- State DONE
  - DONE=1 for exactly one cycle, R_OUT=0, then -> IDLE.
- CLEAR=1
  - Takes priority over START and WR_EN.
  - Next edge: LEVEL=0, OVF=0, R_OUT=0, DONE=0, state IDLE. D_OUT holds.
- Latency
  - START sampled at edge t -> BUSY at t.
  - With EN=1, first token (R_OUT=1, D_OUT=first word) is visible after edge t+1.
  - K tokens are emitted on K consecutive enabled cycles.
  - R_OUT falls and DONE pulses one enabled cycle after the last token.
- Ordering: strict FIFO; the emitted order equals the accepted write order.

Test Plan:
- Load 3, 7, 0xFFFF (N=16), START, EN=1 -> R_OUT=1 for 3 consecutive cycles with D_OUT=3, 7, 0xFFFF; then R_OUT=0 and DONE pulses once; LEVEL ends at 0.
- Load 16 tokens 0..15, then a 17th write of 0xAAAA -> FULL=1, LEVEL=16, OVF=1. Emission then yields 0..15 only; 0xAAAA never appears.
- Load 1, 2, 3, 4, START, toggle EN 1,0,0,1,1,0,1,1 -> D_OUT sequence 1, 2, 3, 4 with R_OUT/D_OUT held during EN=0 cycles; no repeats or skips; DONE after the 4th token plus one enabled cycle.
- START with FIFO empty -> DONE pulses one cycle after START, R_OUT never rises, BUSY returns to 0.
- Load 5 tokens, START, drop RST to 0 after 2 tokens -> all outputs 0 asynchronously. After release, LEVEL=0 and state IDLE; a following START gives an immediate DONE.
- In RUN with LEVEL=1, write 0x1234 in the same cycle as the pop -> 0x1234 is emitted next; DONE only after it. Repeat with CLEAR asserted concurrently -> no further tokens, LEVEL=0, state IDLE.

Source files
------------

// File: rtl/dfg_token_source.sv
// Producer node for the dataflow fabric: the host preloads tokens into a FIFO,
// and START replays them on the R/D interface, one per enabled cycle, ending with a DONE pulse.
module dfg_token_source #(
  parameter int N     = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic          CLEAR,
  input  logic          WR_EN,
  input  logic [N-1:0]  WR_DATA,
  input  logic          START,
  output logic          FULL,
  output logic [AW:0]   LEVEL,
  output logic          OVF,
  output logic          BUSY,
  output logic          DONE,
  output logic          R_OUT,
  output logic [N-1:0]  D_OUT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  state_t        r_state;
  logic [N-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          r_full;
  logic          r_ovf;
  logic          r_busy;
  logic          r_done;
  logic          r_rout;
  logic [N-1:0]  r_dout;

  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [AW:0]   w_level_nxt;

  // A pop frees a slot in the same cycle, so a write to a full FIFO is still taken then.
  assign w_empty = (r_level == '0);
  assign w_pop   = !CLEAR && (r_state == S_RUN) && EN && !w_empty;
  assign w_push  = !CLEAR && WR_EN && (!r_full || w_pop);
  assign w_drop  = !CLEAR && WR_EN && r_full && !w_pop;

  // NOTE: always_comb gets a default assignment first so no path can infer a latch.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + (AW+1)'(1);
      2'b01:   w_level_nxt = r_level - (AW+1)'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // NOTE: token storage has no reset; the pointers and level alone define what is valid.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= WR_DATA;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (CLEAR) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == L_DEPTH);
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rout  <= 1'b0;
      r_dout  <= '0;
    end else if (CLEAR) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rout <= 1'b0;
          r_done <= 1'b0;
          // START is honoured even with EN low; an empty stream completes at once.
          if (START) begin
            if (w_empty) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (EN) begin
            if (w_pop) begin
              r_rout <= 1'b1;
              r_dout <= r_mem[r_rptr];
            end else begin
              r_rout  <= 1'b0;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_rout  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_rout  <= 1'b0;
        end
      endcase
    end
  end

  assign FULL  = r_full;
  assign LEVEL = r_level;
  assign OVF   = r_ovf;
  assign BUSY  = r_busy;
  assign DONE  = r_done;
  assign R_OUT = r_rout;
  assign D_OUT = r_dout;

endmodule

// File: tb/tb_dfg_token_source.sv
// Self-checking bench for dfg_token_source: directed vector table, hand-written
// corner sequences, and random traffic against a queue-based stream model.
module tb_dfg_token_source;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        EN = 1'b0;
  logic        CLEAR = 1'b0;
  logic        WR_EN = 1'b0;
  logic [15:0] WR_DATA = '0;
  logic        START = 1'b0;
  logic        FULL;
  logic [4:0]  LEVEL;
  logic        OVF;
  logic        BUSY;
  logic        DONE;
  logic        R_OUT;
  logic [15:0] D_OUT;

  int n_checks = 0;
  int n_fail   = 0;

  dfg_token_source #(.N(16), .DEPTH(16), .AW(4)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .CLEAR(CLEAR), .WR_EN(WR_EN),
    .WR_DATA(WR_DATA), .START(START), .FULL(FULL), .LEVEL(LEVEL),
    .OVF(OVF), .BUSY(BUSY), .DONE(DONE), .R_OUT(R_OUT), .D_OUT(D_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, clock it, then sample just after the edge.
  task automatic cyc(input logic wr, input logic [15:0] wd, input logic st,
                     input logic en, input logic clr);
    WR_EN = wr; WR_DATA = wd; START = st; EN = en; CLEAR = clr;
    @(posedge CLK);
    #1;
    WR_EN = 1'b0; START = 1'b0; CLEAR = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] wd;
    logic        st;
    logic        en;
    logic        clr;
    logic        e_rout;
    logic [15:0] e_dout;
    logic        e_done;
    logic        e_busy;
    logic [4:0]  e_level;
  } vec_t;

  vec_t tbl [10];

  // Stream model: a token queue plus the three protocol phases.
  typedef enum {M_IDLE, M_RUN, M_DONE} mphase_t;
  logic [15:0] m_q [$];
  mphase_t     m_ph;
  logic        m_rout, m_done, m_ovf;
  logic [15:0] m_dout;

  initial begin
    // Reset state
    #12;
    check("rst_rout", R_OUT, 0);
    check("rst_dout", D_OUT, 0);
    check("rst_done", DONE, 0);
    check("rst_busy", BUSY, 0);
    check("rst_ovf", OVF, 0);
    check("rst_full", FULL, 0);
    check("rst_level", LEVEL, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;

    // Basic stream 3, 7, 0xFFFF
    tbl[0] = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd1};
    tbl[1] = '{1'b1, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd2};
    tbl[2] = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd3};
    tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd3};
    tbl[4] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b1, 5'd2};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b1, 5'd1};
    tbl[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 5'd0};
    tbl[7] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 5'd0};
    tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 5'd0};
    tbl[9] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 5'd0};
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].wr, tbl[i].wd, tbl[i].st, tbl[i].en, tbl[i].clr);
      check($sformatf("vec%0d_rout", i), R_OUT, tbl[i].e_rout);
      check($sformatf("vec%0d_dout", i), D_OUT, tbl[i].e_dout);
      check($sformatf("vec%0d_done", i), DONE, tbl[i].e_done);
      check($sformatf("vec%0d_busy", i), BUSY, tbl[i].e_busy);
      check($sformatf("vec%0d_level", i), LEVEL, tbl[i].e_level);
    end

    // Fill to capacity, overflow write is dropped and flagged
    for (int i = 0; i < 16; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
    check("fill_full", FULL, 1);
    check("fill_level", LEVEL, 16);
    check("fill_ovf", OVF, 0);
    cyc(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
    check("ovf_full", FULL, 1);
    check("ovf_level", LEVEL, 16);
    check("ovf_set", OVF, 1);
    cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    check("ovf_start_busy", BUSY, 1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
      check($sformatf("ovf_tok%0d_rout", i), R_OUT, 1);
      check($sformatf("ovf_tok%0d_dout", i), D_OUT, i);
    end
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    check("ovf_end_rout", R_OUT, 0);
    check("ovf_end_done", DONE, 1);
    check("ovf_sticky", OVF, 1);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    check("clear_ovf", OVF, 0);
    check("clear_done", DONE, 0);

    // Write into a full FIFO in a cycle that also pops
    for (int i = 0; i < 16; i++) cyc(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0);
    check("fullpop_level", LEVEL, 16);
    check("fullpop_full", FULL, 1);
    check("fullpop_ovf", OVF, 0);
    check("fullpop_dout", D_OUT, 16'h0100);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    check("fullpop_clr_level", LEVEL, 0);
    check("fullpop_clr_busy", BUSY, 0);

    // EN gating: pattern 1,0,0,1,1,0,1,1 after START
    begin
      logic       en_pat [8]  = '{1, 0, 0, 1, 1, 0, 1, 1};
      logic       e_rout [8]  = '{1, 1, 1, 1, 1, 1, 1, 0};
      logic [2:0] e_dout [8]  = '{1, 1, 1, 2, 3, 3, 4, 4};
      logic       e_done [8]  = '{0, 0, 0, 0, 0, 0, 0, 1};
      for (int i = 1; i <= 4; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      check("en_start_busy", BUSY, 1);
      check("en_start_rout", R_OUT, 0);
      for (int i = 0; i < 8; i++) begin
        cyc(1'b0, 16'h0, 1'b0, en_pat[i], 1'b0);
        check($sformatf("en%0d_rout", i), R_OUT, e_rout[i]);
        check($sformatf("en%0d_dout", i), D_OUT, 16'(e_dout[i]));
        check($sformatf("en%0d_done", i), DONE, e_done[i]);
      end
      cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
      check("en_after_done", DONE, 0);
      check("en_after_busy", BUSY, 0);
    end

    // START with an empty FIFO
    cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    check("empty_done", DONE, 1);
    check("empty_busy", BUSY, 0);
    check("empty_rout", R_OUT, 0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    check("empty_done_fall", DONE, 0);
    check("empty_rout2", R_OUT, 0);

    // Asynchronous reset in the middle of a run
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'h0050 + 16'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    check("arst_pre_dout", D_OUT, 16'h0051);
    #2 RST = 1'b0;
    #1;
    check("arst_rout", R_OUT, 0);
    check("arst_dout", D_OUT, 0);
    check("arst_busy", BUSY, 0);
    check("arst_level", LEVEL, 0);
    check("arst_full", FULL, 0);
    check("arst_done", DONE, 0);
    check("arst_ovf", OVF, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("arst_rel_level", LEVEL, 0);
    check("arst_rel_busy", BUSY, 0);
    cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    check("arst_start_done", DONE, 1);
    check("arst_start_busy", BUSY, 0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

    // Write concurrent with the last pop extends the stream
    cyc(1'b1, 16'h00A1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 16'h00B2, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    check("ext_tok0", D_OUT, 16'h00A1);
    check("ext_lvl1", LEVEL, 1);
    cyc(1'b1, 16'h1234, 1'b0, 1'b1, 1'b0);
    check("ext_tok1", D_OUT, 16'h00B2);
    check("ext_lvl_same", LEVEL, 1);
    check("ext_nodone", DONE, 0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    check("ext_tok2", D_OUT, 16'h1234);
    check("ext_tok2_rout", R_OUT, 1);
    check("ext_tok2_done", DONE, 0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    check("ext_done", DONE, 1);
    check("ext_rout_fall", R_OUT, 0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

    // Same, but with CLEAR asserted alongside the write
    cyc(1'b1, 16'h00C1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 16'h00D2, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    check("clr_tok0", D_OUT, 16'h00C1);
    cyc(1'b1, 16'h1234, 1'b0, 1'b1, 1'b1);
    check("clr_level", LEVEL, 0);
    check("clr_rout", R_OUT, 0);
    check("clr_busy", BUSY, 0);
    check("clr_done", DONE, 0);
    check("clr_dout_hold", D_OUT, 16'h00C1);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    check("clr_no_tok", R_OUT, 0);
    cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    check("clr_start_done", DONE, 1);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

    // Random traffic against the stream model, from a fresh reset
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    m_q.delete();
    m_ph = M_IDLE; m_rout = 0; m_done = 0; m_ovf = 0; m_dout = '0;
    for (int c = 0; c < 600; c++) begin
      logic        wr, st, en, clr, pop;
      logic [15:0] wd;
      int          sz;
      wr  = ($urandom_range(99) < ((c % 200) < 100 ? 85 : 35));
      wd  = 16'($urandom);
      st  = ($urandom_range(99) < 8);
      en  = ($urandom_range(99) < 75);
      clr = ($urandom_range(99) < 2);
      sz  = m_q.size();
      pop = (m_ph == M_RUN) && en && (sz > 0) && !clr;
      if (clr) begin
        m_q.delete();
        m_ovf = 0; m_rout = 0; m_done = 0; m_ph = M_IDLE;
      end else begin
        if (pop) begin
          m_dout = m_q.pop_front();
          m_rout = 1;
        end
        if (wr) begin
          if (sz < 16 || pop) m_q.push_back(wd);
          else m_ovf = 1;
        end
        case (m_ph)
          M_IDLE: begin
            m_rout = 0; m_done = 0;
            if (st) begin
              if (sz > 0) m_ph = M_RUN;
              else begin m_ph = M_DONE; m_done = 1; end
            end
          end
          M_RUN: if (en && sz == 0) begin
            m_rout = 0; m_done = 1; m_ph = M_DONE;
          end
          default: begin
            m_done = 0; m_rout = 0; m_ph = M_IDLE;
          end
        endcase
      end
      cyc(wr, wd, st, en, clr);
      check($sformatf("rnd%0d_level", c), LEVEL, m_q.size());
      check($sformatf("rnd%0d_full", c), FULL, m_q.size() == 16);
      check($sformatf("rnd%0d_ovf", c), OVF, m_ovf);
      check($sformatf("rnd%0d_busy", c), BUSY, m_ph == M_RUN);
      check($sformatf("rnd%0d_done", c), DONE, m_done);
      check($sformatf("rnd%0d_rout", c), R_OUT, m_rout);
      check($sformatf("rnd%0d_dout", c), D_OUT, m_dout);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
